fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end of the pipeline: owns the architectural PC, issues instruction-bus requests, and delivers `{valid, pc, raw_instr}` to decode. It is the receiving end of the branch/jump redirect that execute produces (`pcSrc` + `target`). It also absorbs decode stalls with a one-entry skid buffer and discards instructions made stale by a redirect.

## Interface
- `RESET_PC`, default 64'h8000_0000, PC fetched first after reset.
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `ireq_valid` out 1: instruction request valid.
- `ireq_addr` out 64: request address, 4-byte aligned.
- `iresp_data_ok` in 1: response valid this cycle for the outstanding request.
- `iresp_data` in 32: instruction word.
- `stall` in 1: decode cannot accept; hold output.
- `redirect_valid` in 1: execute resolved a taken branch or jump.
- `redirect_pc` in 64: redirect target.
- `out_valid` out 1: fetch output valid.
- `out_pc` out 64: PC of `out_raw_instr`.
- `out_raw_instr` out 32: instruction word.
- `out_exc_misalign` out 1: present only under `FETCH_MISALIGN_TRAP_EN`.

## Operation
- At most one request is outstanding. While `ireq_valid`=1, `ireq_addr` is held stable until `iresp_data_ok`. This is a bus rule and overrides redirect.
- `pc_q` holds the next fetch address. On an accepted response in FETCH, `pc_q <= pc_q + 64'd4`, with 64-bit wraparound and no trap.
- The output register is `out_*`. The skid buffer is `buf_valid/buf_pc/buf_instr`.
- States:
  - FETCH: `ireq_valid`=1, `ireq_addr`=`pc_q`.
    - On `data_ok` & !stall: the word goes to the output register, and the fetch stays in FETCH.
    - On `data_ok` & stall & `out_valid`: the word goes to the buffer, then go to HOLD.
    - On `data_ok` & stall & !`out_valid`: the word goes to the output register.
  - HOLD: `ireq_valid`=0. When stall deasserts, the buffer moves to the output register, `buf_valid` is cleared, and the state goes to FETCH.
  - DISCARD: `ireq_valid`=1, address held from the in-flight request. On `data_ok`, the word is dropped and the state goes to FETCH.
- Redirect has priority over stall and over every state transition. In the cycle `redirect_valid`=1:
  - `pc_q <= redirect_pc`.
  - `out_valid <= 0`.
  - `buf_valid <= 0`.
  - Next state:
    - FETCH with `data_ok`=0 goes to DISCARD; the old address stays on the bus.
    - FETCH with `data_ok`=1 drops the word and stays in FETCH.
    - HOLD goes to FETCH.
    - DISCARD stays in DISCARD.
- A redirect that arrives while in DISCARD only updates `pc_q`.
- With stall=1 and no redirect, all `out_*` hold their values.
- With stall=0 and no new word, `out_valid <= 0`.

## Timing
- Reset values (in any cycle where `resetn`=0):
  - `ireq_valid`=0, `out_valid`=0, `out_pc`=0, `out_raw_instr`=0, `out_exc_misalign`=0.
  - `buf_valid`=0, state=FETCH, `pc_q`=`RESET_PC`.
- The first request is on the first cycle with `resetn`=1.
- Reset mid-request aborts the request. The memory side is reset by the same signal.
- Latency: `data_ok` in cycle N gives `out_valid`=1 in N+1. With single-cycle `data_ok`, throughput is 1 instruction per cycle.
- Redirect in cycle N: `ireq_addr`=`redirect_pc` no earlier than N+1. This happens at N+1 if no request is pending, otherwise in the cycle after the stale `data_ok`.
- The first redirected instruction reaches `out_valid` no earlier than N+2.
- `ireq_valid` and `ireq_addr` are driven from registered state only (Moore outputs). `iresp_data_ok` never combinationally affects `ireq_*` in the same cycle.

## Configuration
- `FETCH_MISALIGN_TRAP_EN`
  - Defined:
    - A redirect with `redirect_pc[1:0]`≠0 makes the next output `out_valid`=1, `out_exc_misalign`=1, `out_pc`=`redirect_pc`, `out_raw_instr`=32'h0000_0013 (nop).
    - It then holds `ireq_valid`=0 until the next aligned redirect.
    - Stall holds this output like any other.
  - Undefined:
    - The port is absent.
    - `redirect_pc[1:0]` is forced to 0 before loading `pc_q`.

## Test plan
- Reset release, `data_ok` every cycle, words 0x00000013 upward:
  - -> `ireq_addr` 0x80000000, 0x80000004, 0x80000008 in successive cycles.
  - -> `out_pc` follows one cycle later with matching words.
- `data_ok` delayed 3 cycles:
  - -> `ireq_addr` stable at 0x80000000 for 4 cycles.
  - -> `out_valid`=0 until the cycle after `data_ok`.
- Stall asserted for 3 cycles while `out_valid`=1 and the next word returns:
  - -> `out_*` frozen, state HOLD, `ireq_valid`=0.
  - -> on release, the buffered word appears at `out_pc` +4 and fetching resumes at +8.
- Redirect to 0x80001000 while a request to 0x80000010 is pending, `data_ok` 2 cycles later:
  - -> that response is never output.
  - -> the next `ireq_addr` is 0x80001000 and the next `out_pc` is 0x80001000.
- Redirect and `data_ok` in the same cycle, with stall=1:
  - -> `out_valid`=0 next cycle, the word is dropped, `ireq_addr`=`redirect_pc` next cycle.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 0x80000102:
  - -> one output with `out_exc_misalign`=1 and `out_pc`=0x80000102, then no requests.
  - -> an aligned redirect to 0x80000200 resumes fetching.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the architectural PC, keeps at most one instruction-bus request in
// flight, delivers {valid, pc, raw_instr} to decode, absorbs decode stalls
// with a one-entry skid buffer and drops responses made stale by a redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// produces a single trap output and halts fetching until an aligned redirect).
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  output logic        o_ireq_valid,
  output logic [63:0] o_ireq_addr,
  input  logic        i_iresp_data_ok,
  input  logic [31:0] i_iresp_data,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc,
  output logic        o_out_valid,
  output logic [63:0] o_out_pc,
  output logic [31:0] o_out_raw_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_out_exc_misalign
`endif
);

  // FETCH: request on the bus at r_pc.
  // HOLD: output and skid buffer both full, bus idle until decode drains.
  // DISCARD: a stale request is still in flight; its response is dropped.
  // TRAP: misaligned redirect reported, bus idle until an aligned redirect.
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2,
    S_TRAP    = 2'd3
  } state_t;

  state_t      r_state, w_nextState;
  logic [63:0] r_pc, w_nextPc;
  logic [63:0] r_discAddr, w_nextDiscAddr;
  logic        r_outValid, w_nextOutValid;
  logic [63:0] r_outPc, w_nextOutPc;
  logic [31:0] r_outInstr, w_nextOutInstr;
  logic        r_bufValid, w_nextBufValid;
  logic [63:0] r_bufPc, w_nextBufPc;
  logic [31:0] r_bufInstr, w_nextBufInstr;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic r_outExc, w_nextOutExc;
  logic r_trapPend, w_nextTrapPend;
  logic w_redirMisaligned;

  assign w_redirMisaligned = (i_redirect_pc[1:0] != 2'b00);
  assign o_out_exc_misalign = r_outExc;
`endif

  assign o_out_valid     = r_outValid;
  assign o_out_pc        = r_outPc;
  assign o_out_raw_instr = r_outInstr;

  // Bus request comes only from registered state; reset masks it so no request is seen while resetn is low.
  always_comb begin
    o_ireq_valid = i_resetn && ((r_state == S_FETCH) || (r_state == S_DISCARD));
    o_ireq_addr  = (r_state == S_DISCARD) ? r_discAddr : r_pc;
  end

  // Next-state and datapath: redirect overrides stall and every normal transition.
  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextDiscAddr = r_discAddr;
    w_nextOutValid = r_outValid;
    w_nextOutPc    = r_outPc;
    w_nextOutInstr = r_outInstr;
    w_nextBufValid = r_bufValid;
    w_nextBufPc    = r_bufPc;
    w_nextBufInstr = r_bufInstr;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_nextOutExc   = r_outExc;
    w_nextTrapPend = r_trapPend;
`endif

    if (i_redirect_valid) begin
      w_nextOutValid = 1'b0;
      w_nextBufValid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      w_nextPc       = i_redirect_pc;
      w_nextTrapPend = w_redirMisaligned;
`else
      w_nextPc       = i_redirect_pc & ~64'd3;
`endif
      case (r_state)
        // An unanswered request must stay on the bus, so remember its address and drop its answer later.
        S_FETCH: begin
          if (!i_iresp_data_ok) begin
            w_nextState    = S_DISCARD;
            w_nextDiscAddr = r_pc;
          end
        end
        // The stale answer arriving now completes the old request; only the PC changes otherwise.
        S_DISCARD: begin
          if (i_iresp_data_ok) begin
            w_nextState = S_FETCH;
          end
        end
        default: begin
          w_nextState = S_FETCH;
        end
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_redirMisaligned) begin
        w_nextOutValid = 1'b1;
        w_nextOutPc    = i_redirect_pc;
        w_nextOutInstr = NOP_INSTR;
        w_nextOutExc   = 1'b1;
        if (w_nextState == S_FETCH) begin
          w_nextState = S_TRAP;
        end
      end
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_iresp_data_ok) begin
            w_nextPc = r_pc + 64'd4;
            if (i_stall && r_outValid) begin
              w_nextBufValid = 1'b1;
              w_nextBufPc    = r_pc;
              w_nextBufInstr = i_iresp_data;
              w_nextState    = S_HOLD;
            end else begin
              w_nextOutValid = 1'b1;
              w_nextOutPc    = r_pc;
              w_nextOutInstr = i_iresp_data;
`ifdef FETCH_MISALIGN_TRAP_EN
              w_nextOutExc   = 1'b0;
`endif
            end
          end else if (!i_stall) begin
            w_nextOutValid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            w_nextOutValid = 1'b1;
            w_nextOutPc    = r_bufPc;
            w_nextOutInstr = r_bufInstr;
            w_nextBufValid = 1'b0;
            w_nextState    = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            w_nextOutExc   = 1'b0;
`endif
          end
        end
        S_DISCARD: begin
          if (i_iresp_data_ok) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            w_nextState = r_trapPend ? S_TRAP : S_FETCH;
`else
            w_nextState = S_FETCH;
`endif
          end
          if (!i_stall) begin
            w_nextOutValid = 1'b0;
          end
        end
        default: begin
          if (!i_stall) begin
            w_nextOutValid = 1'b0;
          end
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_discAddr <= 64'd0;
      r_outValid <= 1'b0;
      r_outPc    <= 64'd0;
      r_outInstr <= 32'd0;
      r_bufValid <= 1'b0;
      r_bufPc    <= 64'd0;
      r_bufInstr <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_outExc   <= 1'b0;
      r_trapPend <= 1'b0;
`endif
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_discAddr <= w_nextDiscAddr;
      r_outValid <= w_nextOutValid;
      r_outPc    <= w_nextOutPc;
      r_outInstr <= w_nextOutInstr;
      r_bufValid <= w_nextBufValid;
      r_bufPc    <= w_nextBufPc;
      r_bufInstr <= w_nextBufInstr;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_outExc   <= w_nextOutExc;
      r_trapPend <= w_nextTrapPend;
`endif
    end
  end

endmodule
